elastic_reg_chain: RTL and testbench

- Parametrised successor to the fixed two-entry ping-pong register.
- Cascades STAGES elastic register stages on a valid/ready stream of width W, with a per-build MODE and a synchronous flush.
- Reports total occupancy to upstream credit and debug logic.
- Used to cut long valid, ready and payload timing paths between match, encode and output pipelines.

---
 rtl/elastic_reg_chain_pkg.sv | 14 +
 rtl/elastic_stage.sv | 88 ++++++++
 rtl/elastic_reg_chain.sv | 68 ++++++
 tb/tb_elastic_reg_chain.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_reg_chain_pkg.sv
// Shared definitions for the elastic register chain: stage-type encodings
// and the occupancy counter width helper.
package elastic_reg_chain_pkg;

   localparam int MODE_FULL = 0;
   localparam int MODE_HALF = 1;
   localparam int MODE_PASS = 2;

   // Enough bits to count every slot of a chain of FULL stages.
   function automatic int cw_width(input int stages);
      return $clog2(2 * stages + 1);
   endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic stage on a valid/ready stream: 2-entry FULL, 1-entry HALF or a
// plain PASS wire. rst and flush both empty the stage and block both sides.
module elastic_stage
   import elastic_reg_chain_pkg::*;
#(
   parameter int W    = 8,
   parameter int MODE = MODE_FULL
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_payload,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_payload,
   output logic [1:0]   count
);

   if (MODE == MODE_FULL) begin : g_full
      logic [W-1:0] slot0;
      logic [W-1:0] slot1;
      logic [1:0]   cnt;
      logic         blk;
      logic         push;
      logic         pop;

      assign blk         = rst | flush;
      assign in_ready    = (cnt != 2'd2) && !blk;
      assign out_valid   = (cnt != 2'd0) && !blk;
      assign out_payload = slot0;
      assign count       = cnt;
      assign push        = in_valid && in_ready;
      assign pop         = out_valid && out_ready;

      always_ff @(posedge clk) begin
         if (blk) begin
            cnt <= 2'd0;
         end else begin
            case ({push, pop})
               2'b10: begin
                  if (cnt == 2'd0) slot0 <= in_payload;
                  else             slot1 <= in_payload;
                  cnt <= cnt + 2'd1;
               end
               2'b01: begin
                  slot0 <= slot1;
                  cnt   <= cnt - 2'd1;
               end
               // Push with pop only happens at count 1 since ready is low at 2.
               2'b11:   slot0 <= in_payload;
               default: ;
            endcase
         end
      end
   end else if (MODE == MODE_HALF) begin : g_half
      logic [W-1:0] slot;
      logic         full;
      logic         blk;

      assign blk         = rst | flush;
      assign in_ready    = !full && !blk;
      assign out_valid   = full && !blk;
      assign out_payload = slot;
      assign count       = {1'b0, full};

      always_ff @(posedge clk) begin
         if (blk) begin
            full <= 1'b0;
         end else if (in_valid && in_ready) begin
            slot <= in_payload;
            full <= 1'b1;
         end else if (out_valid && out_ready) begin
            full <= 1'b0;
         end
      end
   end else begin : g_pass
      logic unused_pass;

      assign in_ready    = out_ready;
      assign out_valid   = in_valid;
      assign out_payload = in_payload;
      assign count       = 2'd0;
      assign unused_pass = ^{clk, rst, flush};
   end

endmodule

// File: rtl/elastic_reg_chain.sv
// Cascade of STAGES elastic stages on a valid/ready stream, with flush and a
// total occupancy count for upstream credit and debug logic.
module elastic_reg_chain
   import elastic_reg_chain_pkg::*;
#(
   parameter int W      = 8,
   parameter int STAGES = 2,
   parameter int MODE   = MODE_FULL,
   parameter int CW     = cw_width(STAGES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          input_valid,
   output logic          input_ready,
   input  logic [W-1:0]  input_payload,
   output logic          output_valid,
   input  logic          output_ready,
   output logic [W-1:0]  output_payload,
   output logic [CW-1:0] occupancy
);

   if (STAGES < 1 || MODE < MODE_FULL || MODE > MODE_PASS) begin : g_bad_params
      $error("elastic_reg_chain: STAGES must be >= 1 and MODE in 0..2");
   end

   logic [STAGES:0] link_valid;
   logic [STAGES:0] link_ready;
   logic [W-1:0]    link_payload [STAGES+1];
   logic [1:0]      stage_count  [STAGES];
   logic [CW-1:0]   occ_sum;

   assign link_valid[0]        = input_valid;
   assign link_payload[0]      = input_payload;
   assign input_ready          = link_ready[0];
   assign output_valid         = link_valid[STAGES];
   assign output_payload       = link_payload[STAGES];
   assign link_ready[STAGES]   = output_ready;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      elastic_stage #(
         .W    (W),
         .MODE (MODE)
      ) u_stage (
         .clk         (clk),
         .rst         (rst),
         .flush       (flush),
         .in_valid    (link_valid[i]),
         .in_ready    (link_ready[i]),
         .in_payload  (link_payload[i]),
         .out_valid   (link_valid[i+1]),
         .out_ready   (link_ready[i+1]),
         .out_payload (link_payload[i+1]),
         .count       (stage_count[i])
      );
   end

   always_comb begin
      occ_sum = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_sum = occ_sum + CW'(stage_count[i]);
      end
   end

   // Counts still hold pre-reset contents during the reset cycle itself.
   assign occupancy = rst ? '0 : occ_sum;

endmodule

// File: tb/tb_elastic_reg_chain.sv
// Bench for elastic_reg_chain: five builds checked every cycle against a
// queue-per-stage model, plus directed scenarios with hand-computed values.
module tb_elastic_reg_chain;

   // d0: FULL x2, d1: FULL x3, d2: HALF x2, d3: PASS x2, d4: FULL x1
   localparam int ND       = 5;
   localparam int CAP [ND] = '{2, 2, 1, 0, 2};
   localparam int NST [ND] = '{2, 3, 2, 2, 1};

   logic            clk;
   logic            rst;
   logic            flush;
   logic [4:0]      iv;
   logic [4:0]      ir;
   logic [4:0]      ov;
   logic [4:0]      or_;
   logic [4:0][7:0] ip;
   logic [4:0][7:0] op;
   logic [3:0][2:0] occ_a;
   logic [1:0]      occ4;

   int errors = 0;
   int checks = 0;

   logic [7:0] sq    [ND*3][$];
   logic [7:0] exp_q [ND][$];
   logic [7:0] outs  [ND][$];

   elastic_reg_chain #(.W(8), .STAGES(2), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .flush(flush),
      .input_valid(iv[0]), .input_ready(ir[0]), .input_payload(ip[0]),
      .output_valid(ov[0]), .output_ready(or_[0]), .output_payload(op[0]),
      .occupancy(occ_a[0]));

   elastic_reg_chain #(.W(8), .STAGES(3), .MODE(0)) u1 (
      .clk(clk), .rst(rst), .flush(flush),
      .input_valid(iv[1]), .input_ready(ir[1]), .input_payload(ip[1]),
      .output_valid(ov[1]), .output_ready(or_[1]), .output_payload(op[1]),
      .occupancy(occ_a[1]));

   elastic_reg_chain #(.W(8), .STAGES(2), .MODE(1)) u2 (
      .clk(clk), .rst(rst), .flush(flush),
      .input_valid(iv[2]), .input_ready(ir[2]), .input_payload(ip[2]),
      .output_valid(ov[2]), .output_ready(or_[2]), .output_payload(op[2]),
      .occupancy(occ_a[2]));

   elastic_reg_chain #(.W(8), .STAGES(2), .MODE(2)) u3 (
      .clk(clk), .rst(rst), .flush(flush),
      .input_valid(iv[3]), .input_ready(ir[3]), .input_payload(ip[3]),
      .output_valid(ov[3]), .output_ready(or_[3]), .output_payload(op[3]),
      .occupancy(occ_a[3]));

   elastic_reg_chain #(.W(8), .STAGES(1), .MODE(0)) u4 (
      .clk(clk), .rst(rst), .flush(flush),
      .input_valid(iv[4]), .input_ready(ir[4]), .input_payload(ip[4]),
      .output_valid(ov[4]), .output_ready(or_[4]), .output_payload(op[4]),
      .occupancy(occ4));

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int get_occ(input int d);
      if (d == 4) return int'(occ4);
      return int'(occ_a[d[1:0]]);
   endfunction

   // Per-cycle model: each stage is a queue bounded by its capacity; a word
   // moves forward when the upstream queue is non-empty and the downstream
   // queue had room at the start of the cycle.
   task automatic model_cycle(input int d);
      int         n, b, occ_sum;
      logic       e_ir, e_ov, blk;
      logic [7:0] e_op, w;
      bit         mv [4];
      n = NST[d];
      b = d * 3;
      blk = rst || flush;
      e_op = 8'h00;
      occ_sum = 0;
      if (CAP[d] == 0) begin
         e_ir = or_[d];
         e_ov = iv[d];
         e_op = ip[d];
      end else begin
         e_ir = !blk && (sq[b].size() < CAP[d]);
         e_ov = !blk && (sq[b+n-1].size() > 0);
         if (e_ov) e_op = sq[b+n-1][0];
         if (!rst) for (int s = 0; s < n; s++) occ_sum += sq[b+s].size();
      end
      chk($sformatf("d%0d_input_ready", d), int'(ir[d]), int'(e_ir));
      chk($sformatf("d%0d_output_valid", d), int'(ov[d]), int'(e_ov));
      chk($sformatf("d%0d_occupancy", d), get_occ(d), occ_sum);
      if (e_ov) chk($sformatf("d%0d_output_payload", d), int'(op[d]), int'(e_op));

      // Scoreboard on the DUT's own handshakes: strict FIFO, no drops/dups.
      if (iv[d] && ir[d]) exp_q[d].push_back(ip[d]);
      if (ov[d] && or_[d]) begin
         outs[d].push_back(op[d]);
         if (exp_q[d].size() == 0) chk($sformatf("d%0d_sb_underflow", d), 1, 0);
         else chk($sformatf("d%0d_sb_order", d), int'(op[d]), int'(exp_q[d].pop_front()));
      end

      if (CAP[d] != 0) begin
         if (blk) begin
            exp_q[d].delete();
            for (int s = 0; s < n; s++) sq[b+s].delete();
         end else begin
            mv[0] = iv[d] && (sq[b].size() < CAP[d]);
            for (int s = 1; s < n; s++)
               mv[s] = (sq[b+s-1].size() > 0) && (sq[b+s].size() < CAP[d]);
            mv[n] = (sq[b+n-1].size() > 0) && or_[d];
            for (int s = n; s >= 1; s--) begin
               if (mv[s]) begin
                  w = sq[b+s-1].pop_front();
                  if (s < n) sq[b+s].push_back(w);
               end
            end
            if (mv[0]) sq[b].push_back(ip[d]);
         end
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) model_cycle(d);
   end

   // ---------------- driver tasks (entered/left at posedge + 1) ----------------
   task automatic next_cycle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_one(input int d, input logic [7:0] w);
      bit done;
      done = 1'b0;
      iv[d] = 1'b1;
      ip[d] = w;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         done = ir[d];
         next_cycle(1);
      end
      iv[d] = 1'b0;
      if (!done) chk($sformatf("d%0d_push_timeout", d), 0, 1);
   endtask

   task automatic push_try(input int d, input logic [7:0] base, input int count,
                           input int budget, output int n);
      n = 0;
      iv[d] = 1'b1;
      ip[d] = base;
      for (int k = 0; k < budget && n < count; k++) begin
         @(negedge clk);
         if (ir[d]) n++;
         next_cycle(1);
         ip[d] = 8'(base + n);
      end
      iv[d] = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int n, mx;
      rst = 1'b1; flush = 1'b0; iv = '0; or_ = '0; ip = '0;

      // Reset: blocked during rst, ready on the first cycle after.
      @(negedge clk);
      chk("rst_ready", int'(ir[0]), 0);
      chk("rst_valid", int'(ov[0]), 0);
      chk("rst_occ", get_occ(0), 0);
      next_cycle(1);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready_d0", int'(ir[0]), 1);
      chk("post_rst_ready_d2", int'(ir[2]), 1);
      next_cycle(1);

      // A: FULL x2 streams 0x01..0x10, latency 2, one per cycle.
      outs[0].delete();
      or_[0] = 1'b1;
      iv[0] = 1'b1;
      for (int k = 0; k < 16; k++) begin
         ip[0] = 8'(k + 1);
         @(negedge clk);
         chk("a_ready", int'(ir[0]), 1);
         if (k < 2) chk("a_valid_early", int'(ov[0]), 0);
         else begin
            chk("a_payload", int'(op[0]), k - 1);
            chk("a_occ_steady", get_occ(0), 2);
         end
         next_cycle(1);
      end
      iv[0] = 1'b0;
      next_cycle(4);
      chk("a_out_count", outs[0].size(), 16);
      chk("a_last_word", int'(outs[0][15]), 8'h10);

      // B: FULL x3 under backpressure fills to 6 and holds the head.
      outs[1].delete();
      push_try(1, 8'hA0, 8, 12, n);
      chk("b_accepts", n, 6);
      @(negedge clk);
      chk("b_occ_full", get_occ(1), 6);
      chk("b_ready_low", int'(ir[1]), 0);
      chk("b_head_held", int'(op[1]), 8'hA0);
      next_cycle(1);
      or_[1] = 1'b1;
      iv[1] = 1'b1;
      ip[1] = 8'hA6;
      @(negedge clk);
      chk("b_release_ready", int'(ir[1]), 0);
      chk("b_release_head", int'(op[1]), 8'hA0);
      next_cycle(1);
      push_try(1, 8'hA6, 2, 20, n);
      chk("b_tail_accepts", n, 2);
      next_cycle(10);
      chk("b_out_count", outs[1].size(), 8);
      for (int i = 0; i < 8 && i < outs[1].size(); i++)
         chk("b_drain_order", int'(outs[1][i]), 8'hA0 + i);

      // Boundary on FULL x1: pop at full, input_ready rises one cycle later.
      outs[4].delete();
      push_try(4, 8'hB0, 3, 6, n);
      chk("e1_accepts", n, 2);
      @(negedge clk);
      chk("e1_occ_full", get_occ(4), 2);
      next_cycle(1);
      or_[4] = 1'b1;
      iv[4] = 1'b1;
      ip[4] = 8'hB2;
      @(negedge clk);
      chk("e1_ready_at_full", int'(ir[4]), 0);
      chk("e1_head", int'(op[4]), 8'hB0);
      next_cycle(1);
      @(negedge clk);
      chk("e1_ready_rises", int'(ir[4]), 1);
      chk("e1_next_head", int'(op[4]), 8'hB1);
      next_cycle(1);
      iv[4] = 1'b0;
      next_cycle(4);
      chk("e1_out_count", outs[4].size(), 3);

      // C: HALF x2 moves one word every two cycles.
      outs[2].delete();
      or_[2] = 1'b1;
      iv[2] = 1'b1;
      n = 0;
      mx = 0;
      for (int k = 0; k < 20; k++) begin
         ip[2] = 8'(8'h30 + n);
         @(negedge clk);
         if (ir[2]) n++;
         if (get_occ(2) > mx) mx = get_occ(2);
         next_cycle(1);
      end
      iv[2] = 1'b0;
      chk("c_accepts", n, 10);
      chk("c_outputs_in_window", outs[2].size(), 9);
      chk("c_occ_bound", int'(mx <= 2), 1);
      next_cycle(6);
      chk("c_out_total", outs[2].size(), 10);
      chk("c_last_word", int'(outs[2][outs[2].size()-1]), 8'h39);

      // D: flush with three words held and input_valid high.
      or_[0] = 1'b0;
      push_one(0, 8'h11);
      push_one(0, 8'h22);
      push_one(0, 8'h33);
      flush = 1'b1;
      iv[0] = 1'b1;
      ip[0] = 8'h55;
      @(negedge clk);
      chk("d_flush_ready", int'(ir[0]), 0);
      chk("d_flush_valid", int'(ov[0]), 0);
      next_cycle(1);
      flush = 1'b0;
      iv[0] = 1'b0;
      @(negedge clk);
      chk("d_occ_after", get_occ(0), 0);
      chk("d_valid_after", int'(ov[0]), 0);
      next_cycle(1);
      outs[0].delete();
      or_[0] = 1'b1;
      push_one(0, 8'h44);
      next_cycle(4);
      chk("d_out_count", outs[0].size(), 1);
      if (outs[0].size() > 0) chk("d_first_after_flush", int'(outs[0][0]), 8'h44);

      // E: reset mid-stream with four words held.
      or_[0] = 1'b0;
      push_try(0, 8'h61, 4, 10, n);
      chk("r_accepts", n, 4);
      rst = 1'b1;
      iv[0] = 1'b1;
      ip[0] = 8'h99;
      @(negedge clk);
      chk("r_ready", int'(ir[0]), 0);
      chk("r_valid", int'(ov[0]), 0);
      chk("r_occ", get_occ(0), 0);
      next_cycle(1);
      rst = 1'b0;
      iv[0] = 1'b0;
      @(negedge clk);
      chk("r_ready_after", int'(ir[0]), 1);
      chk("r_occ_after", get_occ(0), 0);
      next_cycle(1);
      outs[0].delete();
      or_[0] = 1'b1;
      next_cycle(4);
      chk("r_no_stale", outs[0].size(), 0);
      push_one(0, 8'h77);
      next_cycle(4);
      chk("r_out_count", outs[0].size(), 1);
      if (outs[0].size() > 0) chk("r_first_word", int'(outs[0][0]), 8'h77);

      // F: PASS mirrors the input in the same cycle, flush has no effect.
      iv[3] = 1'b1;
      or_[3] = 1'b0;
      ip[3] = 8'h5A;
      @(negedge clk);
      chk("p_valid", int'(ov[3]), 1);
      chk("p_ready", int'(ir[3]), 0);
      chk("p_payload", int'(op[3]), 8'h5A);
      chk("p_occ", get_occ(3), 0);
      next_cycle(1);
      flush = 1'b1;
      or_[3] = 1'b1;
      ip[3] = 8'hC3;
      @(negedge clk);
      chk("p_flush_valid", int'(ov[3]), 1);
      chk("p_flush_ready", int'(ir[3]), 1);
      chk("p_flush_payload", int'(op[3]), 8'hC3);
      next_cycle(1);
      flush = 1'b0;
      for (int k = 0; k < 30; k++) begin
         iv[3] = 1'($urandom_range(0, 1));
         or_[3] = 1'($urandom_range(0, 1));
         ip[3] = 8'($urandom_range(0, 255));
         next_cycle(1);
      end
      iv[3] = 1'b0;
      next_cycle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
